// File: rtl/id_stage_pkg.sv
// Shared decode constants for the RV64 instruction-decode stage.
package id_stage_pkg;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  // funct3 codes for loads/stores and the OP/OP-32 ALU groups
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRL = 3'b101;

  // funct7 codes valid for OP and OP-32
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Canonical NOP: ADDI x0, x0, 0
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  typedef enum logic [1:0] {
    OP1_RS1,
    OP1_PC,
    OP1_ZERO
  } op1_sel_e;

endpackage

// File: rtl/id_imm_gen.sv
// Combinational immediate generator: assembles the 32-bit immediate for each
// format and sign-extends it to XLEN from bit 31.
module id_imm_gen
  import id_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:7]             inst_i,
  input  imm_type_e               imm_type_i,
  output logic signed [XLEN-1:0]  imm_o
);

  logic signed [31:0] imm32;

  // Assemble the immediate bits for the selected instruction format
  always_comb begin
    imm32 = '0;
    case (imm_type_i)
      IMM_I:   imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      IMM_S:   imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      IMM_B:   imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      IMM_U:   imm32 = {inst_i[31:12], 12'b0};
      IMM_J:   imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Signed size cast sign-extends to the datapath width
  assign imm_o = XLEN'(imm32);

endmodule

// File: rtl/id_stage.sv
// Registered RV64I decode stage with writeback bypass, load-use stall and
// valid/ready handshakes on both sides.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           inst_i,
  input  logic [XLEN-1:0]       inst_addr_i,
  output logic [REG_ADDR_W-1:0] rs1_addr_o,
  output logic [REG_ADDR_W-1:0] rs2_addr_o,
  input  logic [XLEN-1:0]       rs1_data_i,
  input  logic [XLEN-1:0]       rs2_data_i,
  input  logic                  wb_wen_i,
  input  logic [REG_ADDR_W-1:0] wb_addr_i,
  input  logic [XLEN-1:0]       wb_data_i,
  input  logic                  flush_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           inst_o,
  output logic [XLEN-1:0]       inst_addr_o,
  output logic [XLEN-1:0]       op1_o,
  output logic [XLEN-1:0]       op2_o,
  output logic [XLEN-1:0]       rs2_val_o,
  output logic [XLEN-1:0]       imm_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  reg_wen_o,
  output logic                  is_load_o,
  output logic                  illegal_o
);

  // Source read with same-cycle writeback bypass; x0 always reads zero
  function automatic logic [XLEN-1:0] read_src(
    input logic [REG_ADDR_W-1:0] addr,
    input logic [XLEN-1:0]       rf_data,
    input logic                  wen,
    input logic [REG_ADDR_W-1:0] waddr,
    input logic [XLEN-1:0]       wdata
  );
    if (addr == '0)                          return '0;
    else if (wen && waddr != '0 && waddr == addr) return wdata;
    else                                     return rf_data;
  endfunction

  logic [6:0]              opcode;
  logic [6:0]              funct7;
  logic                    unused_funct3;
  logic                    use_rs1, use_rs2, op2_is_rs2, wen_d, load_d, illegal_d;
  imm_type_e               imm_type;
  op1_sel_e                op1_sel;
  logic signed [XLEN-1:0]  imm_d;
  logic [XLEN-1:0]         rs1_val, rs2_val, op1_d, op2_d;
  logic [REG_ADDR_W-1:0]   rd_d;
  logic                    adv, hazard;

  // Stage p1 (id/ex register) contents
  logic                    vld_p1;
  logic [31:0]             inst_p1;
  logic [XLEN-1:0]         pc_p1, op1_p1, op2_p1, rs2_val_p1, imm_p1;
  logic [REG_ADDR_W-1:0]   rd_p1;
  logic                    wen_p1, load_p1, illegal_p1;

  assign opcode        = inst_i[6:0];
  assign funct7        = inst_i[31:25];
  assign unused_funct3 = ^inst_i[14:12];

  // Opcode decode: source usage, immediate format, operand selects, legality
  always_comb begin
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    op2_is_rs2 = 1'b0;
    wen_d      = 1'b0;
    load_d     = 1'b0;
    illegal_d  = 1'b0;
    imm_type   = IMM_NONE;
    op1_sel    = OP1_RS1;
    case (opcode)
      OPC_LUI:    begin imm_type = IMM_U; op1_sel = OP1_ZERO; wen_d = 1'b1; end
      OPC_AUIPC:  begin imm_type = IMM_U; op1_sel = OP1_PC;   wen_d = 1'b1; end
      OPC_JAL:    begin imm_type = IMM_J; op1_sel = OP1_PC;   wen_d = 1'b1; end
      OPC_JALR:   begin use_rs1 = 1'b1; imm_type = IMM_I; wen_d = 1'b1; end
      OPC_BRANCH: begin use_rs1 = 1'b1; use_rs2 = 1'b1; op2_is_rs2 = 1'b1; imm_type = IMM_B; end
      OPC_LOAD:   begin use_rs1 = 1'b1; imm_type = IMM_I; wen_d = 1'b1; load_d = 1'b1; end
      OPC_STORE:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; imm_type = IMM_S; end
      OPC_OP_IMM: begin use_rs1 = 1'b1; imm_type = IMM_I; wen_d = 1'b1; end
      OPC_OP: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; op2_is_rs2 = 1'b1; wen_d = 1'b1;
        illegal_d = (funct7 != F7_BASE) && (funct7 != F7_ALT);
      end
      OPC_OP_IMM_32: begin
        if (XLEN == 32) illegal_d = 1'b1;
        else begin use_rs1 = 1'b1; imm_type = IMM_I; wen_d = 1'b1; end
      end
      OPC_OP_32: begin
        if (XLEN == 32) illegal_d = 1'b1;
        else begin use_rs1 = 1'b1; use_rs2 = 1'b1; op2_is_rs2 = 1'b1; wen_d = 1'b1; end
      end
      default: illegal_d = 1'b1;
    endcase
    if (illegal_d) begin
      use_rs1  = 1'b0;
      use_rs2  = 1'b0;
      wen_d    = 1'b0;
      load_d   = 1'b0;
      imm_type = IMM_NONE;
    end
  end

  id_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst_i     (inst_i[31:7]),
    .imm_type_i (imm_type),
    .imm_o      (imm_d)
  );

  assign rs1_addr_o = use_rs1 ? REG_ADDR_W'(inst_i[19:15]) : '0;
  assign rs2_addr_o = use_rs2 ? REG_ADDR_W'(inst_i[24:20]) : '0;
  assign rs1_val    = read_src(rs1_addr_o, rs1_data_i, wb_wen_i, wb_addr_i, wb_data_i);
  assign rs2_val    = read_src(rs2_addr_o, rs2_data_i, wb_wen_i, wb_addr_i, wb_data_i);
  assign rd_d       = illegal_d ? '0 : REG_ADDR_W'(inst_i[11:7]);

  // Operand selection; illegal encodings issue with zeroed operands
  always_comb begin
    op1_d = '0;
    op2_d = '0;
    if (!illegal_d) begin
      case (op1_sel)
        OP1_PC:   op1_d = inst_addr_i;
        OP1_ZERO: op1_d = '0;
        default:  op1_d = rs1_val;
      endcase
      op2_d = op2_is_rs2 ? rs2_val : imm_d;
    end
  end

  // Handshake: unused sources are zero, so a match with rd!=0 is a real use
  assign adv      = !vld_p1 || out_ready;
  assign hazard   = vld_p1 && load_p1 && (rd_p1 != '0) &&
                    ((rs1_addr_o == rd_p1) || (rs2_addr_o == rd_p1));
  assign in_ready = adv && !hazard && !flush_i;

  // Stage p0 -> p1: id/ex register; reset over flush over advance
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1     <= 1'b0;
      inst_p1    <= '0;
      pc_p1      <= '0;
      op1_p1     <= '0;
      op2_p1     <= '0;
      rs2_val_p1 <= '0;
      imm_p1     <= '0;
      rd_p1      <= '0;
      wen_p1     <= 1'b0;
      load_p1    <= 1'b0;
      illegal_p1 <= 1'b0;
    end else if (flush_i) begin
      vld_p1     <= 1'b0;
    end else if (adv) begin
      vld_p1     <= in_valid && in_ready;
      inst_p1    <= inst_i;
      pc_p1      <= inst_addr_i;
      op1_p1     <= op1_d;
      op2_p1     <= op2_d;
      rs2_val_p1 <= rs2_val;
      imm_p1     <= imm_d;
      rd_p1      <= rd_d;
      wen_p1     <= wen_d && (rd_d != '0);
      load_p1    <= load_d;
      illegal_p1 <= illegal_d;
    end
  end

  assign out_valid   = vld_p1;
  assign inst_o      = inst_p1;
  assign inst_addr_o = pc_p1;
  assign op1_o       = op1_p1;
  assign op2_o       = op2_p1;
  assign rs2_val_o   = rs2_val_p1;
  assign imm_o       = imm_p1;
  assign rd_addr_o   = rd_p1;
  assign reg_wen_o   = wen_p1;
  assign is_load_o   = load_p1;
  assign illegal_o   = illegal_p1;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode, bypass, load-use stall, backpressure,
// flush and illegal encodings.
module tb_id_stage;

  localparam int XLEN = 64;
  localparam int RAW  = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst_i;
  logic [XLEN-1:0] inst_addr_i;
  logic [RAW-1:0]  rs1_addr_o, rs2_addr_o;
  logic [XLEN-1:0] rs1_data_i, rs2_data_i;
  logic            wb_wen_i;
  logic [RAW-1:0]  wb_addr_i;
  logic [XLEN-1:0] wb_data_i;
  logic            flush_i;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     inst_o;
  logic [XLEN-1:0] inst_addr_o, op1_o, op2_o, rs2_val_o, imm_o;
  logic [RAW-1:0]  rd_addr_o;
  logic            reg_wen_o, is_load_o, illegal_o;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  id_stage #(.XLEN(XLEN), .REG_ADDR_W(RAW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .inst_i      (inst_i),
    .inst_addr_i (inst_addr_i),
    .rs1_addr_o  (rs1_addr_o),
    .rs2_addr_o  (rs2_addr_o),
    .rs1_data_i  (rs1_data_i),
    .rs2_data_i  (rs2_data_i),
    .wb_wen_i    (wb_wen_i),
    .wb_addr_i   (wb_addr_i),
    .wb_data_i   (wb_data_i),
    .flush_i     (flush_i),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .inst_o      (inst_o),
    .inst_addr_o (inst_addr_o),
    .op1_o       (op1_o),
    .op2_o       (op2_o),
    .rs2_val_o   (rs2_val_o),
    .imm_o       (imm_o),
    .rd_addr_o   (rd_addr_o),
    .reg_wen_o   (reg_wen_o),
    .is_load_o   (is_load_o),
    .illegal_o   (illegal_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush_i = 1'b0;
    inst_i = 32'h0; inst_addr_i = '0; rs1_data_i = '0; rs2_data_i = '0;
    wb_wen_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
    step(); step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_op1",       op1_o,          64'd0);
    chk("rst_inst",      64'(inst_o),    64'd0);
    chk("rst_reg_wen",   64'(reg_wen_o), 64'd0);

    // ADDI x1,x0,5 ; rs1_data garbage must be ignored since rs1=x0
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    inst_i = 32'h0050_0093; inst_addr_i = 64'h8000_0000; rs1_data_i = 64'hDEAD;
    #1;
    chk("addi_in_ready", 64'(in_ready),   64'd1);
    chk("addi_rs2_addr", 64'(rs2_addr_o), 64'd0);
    step();
    chk("addi_valid", 64'(out_valid),  64'd1);
    chk("addi_op1",   op1_o,           64'd0);
    chk("addi_op2",   op2_o,           64'd5);
    chk("addi_imm",   imm_o,           64'd5);
    chk("addi_rd",    64'(rd_addr_o),  64'd1);
    chk("addi_wen",   64'(reg_wen_o),  64'd1);
    chk("addi_pc",    inst_addr_o,     64'h8000_0000);

    // BNE x1,x2,-8
    inst_i = 32'hFE20_9CE3; rs1_data_i = 64'd3; rs2_data_i = 64'd7;
    step();
    chk("bne_op1",  op1_o,          64'd3);
    chk("bne_op2",  op2_o,          64'd7);
    chk("bne_imm",  imm_o,          64'hFFFF_FFFF_FFFF_FFF8);
    chk("bne_wen",  64'(reg_wen_o), 64'd0);
    chk("bne_rs2v", rs2_val_o,      64'd7);

    // ADD x3,x1,x2 with writeback to x2 in the same cycle
    inst_i = 32'h0020_81B3; rs2_data_i = 64'h11;
    wb_wen_i = 1'b1; wb_addr_i = 5'd2; wb_data_i = 64'h55;
    step();
    chk("add_op1",  op1_o,          64'd3);
    chk("add_op2",  op2_o,          64'h55);
    chk("add_rs2v", rs2_val_o,      64'h55);
    chk("add_rd",   64'(rd_addr_o), 64'd3);
    wb_wen_i = 1'b0;

    // LD x5,0(x1) then dependent ADD x6,x5,x5
    inst_i = 32'h0000_B283;
    step();
    chk("ld_valid", 64'(out_valid), 64'd1);
    chk("ld_load",  64'(is_load_o), 64'd1);
    chk("ld_rd",    64'(rd_addr_o), 64'd5);
    inst_i = 32'h0052_8333;
    #1;
    chk("haz_in_ready", 64'(in_ready), 64'd0);
    step();
    chk("haz_bubble",     64'(out_valid), 64'd0);
    chk("haz_in_ready_2", 64'(in_ready),  64'd1);
    step();
    chk("dep_valid", 64'(out_valid), 64'd1);
    chk("dep_rd",    64'(rd_addr_o), 64'd6);
    chk("dep_load",  64'(is_load_o), 64'd0);

    // LUI x7,0x12345 held under backpressure while inst_i changes
    inst_i = 32'h1234_53B7;
    step();
    chk("lui_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b0;
    inst_i = 32'h0050_0093;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      step();
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_op2",   op2_o,          64'h1234_5000);
      chk("hold_imm",   imm_o,          64'h1234_5000);
      chk("hold_op1",   op1_o,          64'd0);
      chk("hold_inst",  64'(inst_o),    64'h1234_53B7);
      chk("hold_rd",    64'(rd_addr_o), 64'd7);
    end

    // Release, ADDI is captured, then flush it while it is held
    out_ready = 1'b1;
    step();
    chk("addi2_valid", 64'(out_valid), 64'd1);
    chk("addi2_inst",  64'(inst_o),    64'h0050_0093);
    out_ready = 1'b0; flush_i = 1'b1;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    step();
    chk("flush_valid", 64'(out_valid), 64'd0);
    flush_i = 1'b0; out_ready = 1'b1;

    // Unknown opcode
    inst_i = 32'h0000_007F;
    step();
    chk("ill_valid", 64'(out_valid), 64'd1);
    chk("ill_flag",  64'(illegal_o), 64'd1);
    chk("ill_wen",   64'(reg_wen_o), 64'd0);
    chk("ill_imm",   imm_o,          64'd0);

    // OP with bad funct7 (would otherwise be ADD x3,x1,x2)
    inst_i = 32'h8020_81B3;
    step();
    chk("f7_flag", 64'(illegal_o), 64'd1);
    chk("f7_rd",   64'(rd_addr_o), 64'd0);
    chk("f7_op1",  op1_o,          64'd0);

    // AUIPC x1,1 at PC 0x80000000
    inst_i = 32'h0000_1097;
    step();
    chk("auipc_op1", op1_o,          64'h8000_0000);
    chk("auipc_op2", op2_o,          64'h1000);
    chk("auipc_ill", 64'(illegal_o), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
